// File: rtl/register_file.sv
// rtl/register_file.sv - 32 x N integer register file, one write port, two mux32 read ports
// x00 has no storage; reads of index 0 return zero through the mux input tied low.

module mux32 #(
  parameter int N = 32
) (
  input  logic [31:0][N-1:0] i_in,
  input  logic [4:0]         i_sel,
  output logic [N-1:0]       o_out
);
  assign o_out = i_in[i_sel];
endmodule

module register_file #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [4:0]   rd_addr0,
  output logic [N-1:0] rd_data0,
  input  logic [4:0]   rd_addr1,
  output logic [N-1:0] rd_data1
);
  logic [N-1:0]       r_regs [1:31];
  logic [31:1]        w_wr_en;
  logic [31:0][N-1:0] w_bank;

  // Decoder output for index 0 is never formed, so writes to x00 vanish.
  always_comb begin
    w_wr_en = '0;
    for (int i = 1; i < 32; i++) begin
      w_wr_en[i] = wr_ena && (wr_addr == 5'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_wr_en[i]) begin
          r_regs[i] <= wr_data;
        end
      end
    end
  end

  assign w_bank[0] = '0;
  for (genvar g = 1; g < 32; g++) begin : g_bank
    assign w_bank[g] = r_regs[g];
  end

  mux32 #(.N(N)) u_rd_mux0 (
    .i_in  (w_bank),
    .i_sel (rd_addr0),
    .o_out (rd_data0)
  );

  mux32 #(.N(N)) u_rd_mux1 (
    .i_in  (w_bank),
    .i_sel (rd_addr1),
    .o_out (rd_data1)
  );
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed and randomized checks of register_file against an array model
module tb_register_file;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_ena;
  logic [4:0]   wr_addr;
  logic [N-1:0] wr_data;
  logic [4:0]   rd_addr0;
  logic [N-1:0] rd_data0;
  logic [4:0]   rd_addr1;
  logic [N-1:0] rd_data1;

  logic [N-1:0] model [32];
  int n_cmp = 0;
  int n_err = 0;

  register_file #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_data0 (rd_data0),
    .rd_addr1 (rd_addr1),
    .rd_data1 (rd_data1)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [N-1:0] d);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr_ena = 1'b0;
    if (rst && a != 5'd0) model[a] = d;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a0, input logic [4:0] a1);
    rd_addr0 = a0; rd_addr1 = a1;
    #1;
    check({tag, "_p0"}, rd_data0, model[a0]);
    check({tag, "_p1"}, rd_data1, model[a1]);
  endtask

  initial begin
    rst = 1'b0; wr_ena = 1'b0; wr_addr = '0; wr_data = '0; rd_addr0 = '0; rd_addr1 = '0;
    model_clear();
    #2;
    for (int i = 0; i < 32; i += 7) read_check("por", 5'(i), 5'(31 - i));
    @(negedge clk); rst = 1'b1;

    // Fill with ones, then pulse reset between edges and read every address at once.
    for (int i = 0; i < 32; i++) do_write(5'(i), 32'hFFFF_FFFF);
    read_check("fill", 5'd1, 5'd31);
    @(negedge clk);
    #2 rst = 1'b0;
    model_clear();
    #1;
    for (int i = 0; i < 32; i++) begin
      rd_addr0 = 5'(i); rd_addr1 = 5'(i);
      #0.1;
      check("async_rst_p0", rd_data0, 32'h0);
      check("async_rst_p1", rd_data1, 32'h0);
    end
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h5555_AAAA;
    @(posedge clk); #1;
    wr_ena = 1'b0;
    read_check("wr_in_rst", 5'd3, 5'd3);
    @(negedge clk); rst = 1'b1;

    // Write/read sweep with crossed read addresses.
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 | i);
    for (int i = 1; i < 32; i++) begin
      read_check("sweep", 5'(i), 5'(31 - i));
      check("sweep_const", rd_data0, 32'hA5A5_0000 | i);
    end

    // x00 protection.
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEAD_BEEF; rd_addr0 = 5'd0;
    #1 check("x0_pre", rd_data0, 32'h0);
    @(posedge clk); #1;
    check("x0_post", rd_data0, 32'h0);
    wr_ena = 1'b0;

    // Write-enable gating.
    do_write(5'd5, 32'h1234_5678);
    @(negedge clk);
    wr_ena = 1'b0; wr_addr = 5'd5; wr_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    #1;
    check("gate_p0", rd_data0, 32'h1234_5678);
    check("gate_p1", rd_data1, 32'h1234_5678);

    // Same-cycle read/write: no bypass.
    do_write(5'd7, 32'h1111_1111);
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h2222_2222; rd_addr1 = 5'd7;
    #1 check("rw_pre", rd_data1, 32'h1111_1111);
    @(posedge clk); #1;
    check("rw_post", rd_data1, 32'h2222_2222);
    wr_ena = 1'b0;
    model[7] = 32'h2222_2222;

    // Reset asserted coincident with a write.
    @(negedge clk);
    wr_ena = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE_F00D;
    @(posedge clk);
    rst = 1'b0;
    #1;
    wr_ena = 1'b0;
    model_clear();
    rd_addr0 = 5'd10;
    #1 check("rst_mid_wr", rd_data0, 32'h0);
    @(negedge clk); rst = 1'b1;
    do_write(5'd10, 32'h0000_0042);
    rd_addr0 = 5'd10;
    #1 check("after_rst_wr", rd_data0, 32'h0000_0042);

    // Randomized traffic against the array model.
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      wr_ena   = 1'($urandom_range(0, 1));
      wr_addr  = 5'($urandom);
      wr_data  = $urandom;
      rd_addr0 = 5'($urandom);
      rd_addr1 = 5'($urandom);
      #1;
      check("rand_pre_p0", rd_data0, model[rd_addr0]);
      check("rand_pre_p1", rd_data1, model[rd_addr1]);
      @(posedge clk); #1;
      if (wr_ena && wr_addr != 5'd0) model[wr_addr] = wr_data;
      check("rand_post_p0", rd_data0, model[rd_addr0]);
      check("rand_post_p1", rd_data1, model[rd_addr1]);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b0;
        model_clear();
        #1;
        check("rand_rst_p0", rd_data0, 32'h0);
        check("rand_rst_p1", rd_data1, 32'h0);
        @(negedge clk); rst = 1'b1;
      end
    end
    wr_ena = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
